// File: rtl/snn_weight_loader_if.sv
// Stream-in / weight-bus-out bundle of the SNN weight loader.
// The slave modport is the loader; the master modport is the host feeding words and observing writes.
interface snn_weight_loader_if #(
  parameter int N_NEURON   = 4,
  parameter int W_WIDTH    = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                  s_valid;
  logic                  s_ready;
  logic [W_WIDTH-1:0]    s_data;
  logic [N_NEURON-1:0]   weight_wr;
  logic [ADDR_WIDTH-1:0] weight_addr;
  logic [W_WIDTH-1:0]    weight_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, weight_wr, weight_addr, weight_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, weight_wr, weight_addr, weight_data
  );
endinterface

// File: rtl/snn_weight_loader.sv
// Turns a frame of 2 threshold words + N_NEURON*N_CHANNEL weights into one-hot neuron writes, one cycle after each beat.
// One word per clock; s_ready is high in every non-idle state except while abort is asserted.
module snn_weight_loader #(
  parameter int                 N_NEURON   = 4,
  parameter int                 N_CHANNEL  = 4,
  parameter int                 W_WIDTH    = 8,
  parameter int                 T_WIDTH    = 2*W_WIDTH,
  parameter logic [T_WIDTH-1:0] THR_RESET  = 16'h0100,
  parameter int                 ADDR_WIDTH = (N_CHANNEL > 1) ? $clog2(N_CHANNEL) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  snn_weight_loader_if.slave  bus,
  output logic [T_WIDTH-1:0]  threshold,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int NW = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
  localparam logic [NW-1:0]         N_LAST = NW'(N_NEURON - 1);
  localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(N_CHANNEL - 1);

  typedef enum logic [1:0] {S_IDLE, S_THR_LO, S_THR_HI, S_WEIGHTS} state_t;

  state_t                r_state, w_state_nxt;
  logic [NW-1:0]         r_nidx;
  logic [ADDR_WIDTH-1:0] r_cidx;
  logic [W_WIDTH-1:0]    r_shadow;
  logic [T_WIDTH-1:0]    r_threshold;
  logic [N_NEURON-1:0]   r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [W_WIDTH-1:0]    r_data;
  logic                  r_done, r_err;

  logic                  w_beat, w_last, w_clr, w_wbeat;
  logic [N_NEURON-1:0]   w_onehot;

  assign busy          = (r_state != S_IDLE);
  assign bus.s_ready   = busy && !abort;
  assign w_beat        = bus.s_valid && bus.s_ready;
  assign w_wbeat       = w_beat && (r_state == S_WEIGHTS);
  assign w_last        = (r_nidx == N_LAST) && (r_cidx == C_LAST);

  assign bus.weight_wr   = r_wr;
  assign bus.weight_addr = r_addr;
  assign bus.weight_data = r_data;
  assign threshold       = r_threshold;
  assign done            = r_done;
  assign err             = r_err;

  always_comb begin
    w_state_nxt      = r_state;
    w_clr            = 1'b0;
    w_onehot         = '0;
    w_onehot[r_nidx] = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_THR_LO;
          w_clr       = 1'b1;
        end
      end
      S_THR_LO:  if (w_beat) w_state_nxt = S_THR_HI;
      S_THR_HI:  if (w_beat) w_state_nxt = S_WEIGHTS;
      S_WEIGHTS: if (w_beat && w_last) w_state_nxt = S_IDLE;
    endcase
    // Abort outranks everything except the idle start request.
    if (abort && busy) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nidx <= '0;
      r_cidx <= '0;
    end else if (w_clr) begin
      r_nidx <= '0;
      r_cidx <= '0;
    end else if (w_wbeat) begin
      if (r_cidx == C_LAST) begin
        r_cidx <= '0;
        r_nidx <= (r_nidx == N_LAST) ? '0 : r_nidx + 1'b1;
      end else begin
        r_cidx <= r_cidx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow    <= '0;
      r_threshold <= THR_RESET;
      r_wr        <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wr   <= w_wbeat ? w_onehot : '0;
      r_done <= w_wbeat && w_last;
      r_err  <= abort && busy;
      if (w_wbeat) begin
        r_addr <= r_cidx;
        r_data <= bus.s_data;
      end
      if (w_beat && r_state == S_THR_LO) r_shadow <= bus.s_data;
      if (w_beat && r_state == S_THR_HI) r_threshold <= {bus.s_data, r_shadow};
    end
  end
endmodule

// File: tb/tb_snn_weight_loader.sv
// Directed-sequence bench with random words: a 4x4 loader checked against a frame-level write model,
// plus a 3x3 loader checking non-power-of-two channel wrap.
module tb_snn_weight_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, start_b, abort_b;
  logic [15:0] threshold, threshold_b;
  logic        busy, done, err, busy_b, done_b, err_b;

  snn_weight_loader_if #(.N_NEURON(4), .W_WIDTH(8), .ADDR_WIDTH(2)) ifa ();
  snn_weight_loader_if #(.N_NEURON(3), .W_WIDTH(8), .ADDR_WIDTH(2)) ifb ();

  snn_weight_loader #(.N_NEURON(4), .N_CHANNEL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bus(ifa.slave),
    .threshold(threshold), .busy(busy), .done(done), .err(err)
  );

  snn_weight_loader #(.N_NEURON(3), .N_CHANNEL(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .bus(ifb.slave),
    .threshold(threshold_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  typedef struct {
    logic [3:0] wr;
    logic [1:0] addr;
    logic [7:0] data;
    logic       dn;
    int         cyc;
  } ev_t;

  ev_t mon_q[$];
  ev_t mon_b[$];
  int  cyc = 0, done_cnt = 0, err_cnt = 0, spurious = 0, done_b_cnt = 0;
  bit  prev_beat = 1'b0;
  int  errors = 0, checks = 0;
  int  gap_pct = 0;
  bit  start_noise = 1'b0;
  logic [7:0] fw[$];

  // Observers: record every strobe / done pulse, count err pulses and strobes not preceded by a beat.
  always @(negedge clk) begin
    cyc++;
    if (ifa.weight_wr != 0 || done)
      mon_q.push_back('{ifa.weight_wr, ifa.weight_addr, ifa.weight_data, done, cyc});
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (ifa.weight_wr != 0 && !prev_beat) spurious++;
    prev_beat = ifa.s_valid && ifa.s_ready;
    if (ifb.weight_wr != 0 || done_b)
      mon_b.push_back('{{1'b0, ifb.weight_wr}, ifb.weight_addr, ifb.weight_data, done_b, cyc});
    if (done_b) done_b_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    ifa.s_data = d;
    while (!acc && guard < 200) begin
      ifa.s_valid = ($urandom_range(99) >= gap_pct);
      start = start_noise ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
      acc = ifa.s_valid && ifa.s_ready;
      tick();
      guard++;
    end
    ifa.s_valid = 1'b0;
    start = 1'b0;
    check("push_accept", 32'(acc), 32'd1);
  endtask

  task automatic do_start(input bit with_abort);
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    if (with_abort) begin
      @(negedge clk);
      check("sa_ready", 32'(ifa.s_ready), 32'd1);
      check("sa_no_err", 32'(err), 32'd0);
      tick();
    end
  endtask

  task automatic clear_mon();
    mon_q.delete();
    done_cnt = 0;
    err_cnt = 0;
    spurious = 0;
  endtask

  // Reference: weight k of a frame goes to neuron k/4, channel k%4, carrying word k+2.
  task automatic verify_writes(input int n, input string tag);
    check({tag, "_nwr"}, mon_q.size(), n);
    for (int k = 0; k < n && k < mon_q.size(); k++)
      check($sformatf("%s_wr%0d", tag, k),
            {18'd0, mon_q[k].wr, mon_q[k].addr, mon_q[k].data},
            {18'd0, 4'(1 << (k / 4)), 2'(k % 4), fw[k+2]});
  endtask

  task automatic run_frame(input bit with_abort, input string tag);
    clear_mon();
    do_start(with_abort);
    foreach (fw[i]) push(fw[i]);
    repeat (2) tick();
    check({tag, "_thr"}, 32'(threshold), 32'({fw[1], fw[0]}));
    verify_writes(16, tag);
    check({tag, "_done_cnt"}, done_cnt, 1);
    if (mon_q.size() > 0)
      check({tag, "_done_last"}, 32'(mon_q[mon_q.size()-1].dn), 32'd1);
    check({tag, "_spurious"}, spurious, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    if (gap_pct == 0 && mon_q.size() > 0)
      check({tag, "_span"}, mon_q[mon_q.size()-1].cyc - mon_q[0].cyc, 15);
  endtask

  task automatic rand_frame();
    fw.delete();
    for (int i = 0; i < 18; i++) fw.push_back(8'($urandom));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int beats_b;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    ifa.s_valid = 1'b0; ifa.s_data = '0; ifb.s_valid = 1'b0; ifb.s_data = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_bus", {18'd0, ifa.weight_wr, ifa.weight_addr, ifa.weight_data}, 32'd0);
    check("rst_flags", {28'd0, ifa.s_ready, busy, done, err}, 32'd0);
    check("rst_thr", 32'(threshold), 32'h0100);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Abort while waiting for the high threshold word.
    clear_mon();
    do_start(1'b0);
    push(8'h55);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("thrhi_err", 32'(err), 32'd1);
    check("thrhi_busy", 32'(busy), 32'd0);
    check("thrhi_thr", 32'(threshold), 32'h0100);
    tick();
    @(negedge clk);
    check("thrhi_err_once", 32'(err), 32'd0);
    tick();
    check("thrhi_nwr", mon_q.size(), 0);
    check("thrhi_err_cnt", err_cnt, 1);

    // Reference frame, stream held valid.
    fw = {8'h00, 8'h02};
    for (int i = 1; i <= 16; i++) fw.push_back(8'(i));
    run_frame(1'b0, "full");
    check("full_thr_0200", 32'(threshold), 32'h0200);

    // Same frame with random stream gaps.
    gap_pct = 50;
    run_frame(1'b0, "gaps");
    gap_pct = 0;

    // Abort after five weight beats; the beat offered with abort must be refused.
    rand_frame();
    clear_mon();
    do_start(1'b0);
    for (int i = 0; i < 7; i++) push(fw[i]);
    abort = 1'b1;
    ifa.s_valid = 1'b1;
    ifa.s_data = fw[7];
    @(negedge clk);
    check("ab5_ready", 32'(ifa.s_ready), 32'd0);
    tick();
    abort = 1'b0;
    ifa.s_valid = 1'b0;
    @(negedge clk);
    check("ab5_err", 32'(err), 32'd1);
    check("ab5_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    verify_writes(5, "ab5");
    check("ab5_err_cnt", err_cnt, 1);
    check("ab5_done_cnt", done_cnt, 0);
    check("ab5_thr", 32'(threshold), 32'({fw[1], fw[0]}));

    // Restart after abort begins at neuron 0, channel 0.
    rand_frame();
    run_frame(1'b0, "restart");

    // Stray start pulses while busy.
    rand_frame();
    start_noise = 1'b1;
    run_frame(1'b0, "noise");
    start_noise = 1'b0;

    // Start and abort together in idle.
    rand_frame();
    run_frame(1'b1, "startabort");

    // Asynchronous reset in the middle of the weight phase.
    rand_frame();
    do_start(1'b0);
    for (int i = 0; i < 5; i++) push(fw[i]);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_bus", {18'd0, ifa.weight_wr, ifa.weight_addr, ifa.weight_data}, 32'd0);
    check("mrst_flags", {28'd0, ifa.s_ready, busy, done, err}, 32'd0);
    check("mrst_thr", 32'(threshold), 32'h0100);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // 3x3 loader: channel wraps 2 -> 0, frame of 11 beats.
    mon_b.delete();
    done_b_cnt = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    ifb.s_valid = 1'b1;
    ifb.s_data = 8'd1;
    beats_b = 0;
    for (int g = 0; g < 40 && beats_b < 11; g++) begin
      @(negedge clk);
      if (ifb.s_valid && ifb.s_ready) beats_b++;
      tick();
      ifb.s_data = 8'(beats_b + 1);
    end
    ifb.s_valid = 1'b0;
    repeat (2) tick();
    check("b_beats", beats_b, 11);
    check("b_nwr", mon_b.size(), 9);
    for (int k = 0; k < 9 && k < mon_b.size(); k++)
      check($sformatf("b_wr%0d", k), {18'd0, mon_b[k].wr, mon_b[k].addr, mon_b[k].data},
            {18'd0, 4'(1 << (k / 3)), 2'(k % 3), 8'(k + 3)});
    check("b_done_cnt", done_b_cnt, 1);
    if (mon_b.size() > 0)
      check("b_done_last", 32'(mon_b[mon_b.size()-1].dn), 32'd1);
    check("b_thr", 32'(threshold_b), 32'h0201);
    check("b_busy", 32'(busy_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
